// File: rtl/tetris_pkg.sv
// Shared types and constants for the piece sequencer and its piece queue.
package tetris_pkg;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_t;

  localparam logic [2:0] PIECE_NONE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEED   = 3'd1,
    ST_WARM   = 3'd2,
    ST_ROLL   = 3'd3,
    ST_REROLL = 3'd4,
    ST_READY  = 3'd5
  } seq_state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by this value.
  localparam logic [31:0] DEFAULT_SEED = 32'h1F;

  function automatic logic [2:0] mod7_5b(input logic [4:0] v);
    logic [4:0] r;
    r = v % 5'd7;
    return r[2:0];
  endfunction

endpackage

// File: rtl/piece_queue.sv
// Circular FIFO of 3-bit piece ids exposing the head and the entry behind it.
module piece_queue #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [2:0]                   push_data_i,
  input  logic                         pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         head_valid_o,
  output logic [2:0]                   head_o,
  output logic                         head1_valid_o,
  output logic [2:0]                   head1_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_nxt;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push    = push_i && (count_q != CW'(DEPTH));
  assign do_pop     = pop_i && (count_q != '0);
  assign rd_ptr_nxt = ptr_inc(rd_ptr_q);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = rd_ptr_nxt;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are masked by the valid flags.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o       = count_q;
  assign head_valid_o  = (count_q >= CW'(1));
  assign head1_valid_o = (count_q >= CW'(2));
  assign head_o        = head_valid_o  ? mem_q[rd_ptr_q]   : 3'd0;
  assign head1_o       = head1_valid_o ? mem_q[rd_ptr_nxt] : 3'd0;

endmodule

// File: rtl/piece_sequencer.sv
// Seeds the external RNG, warms it up, and rolls NES-style pieces into a small queue.
module piece_sequencer
  import tetris_pkg::*;
#(
  parameter int WARMUP = 16,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] seed_in,
  output logic        rng_load,
  output logic [31:0] rng_seed,
  input  logic [31:0] rng_state,
  output logic        piece_valid,
  input  logic        piece_ready,
  output logic [2:0]  piece_id,
  output logic        preview_valid,
  output logic [2:0]  preview_id,
  output logic        busy,
  output seq_state_t  dbg_state_o
);

  // Handshake: the head is consumed in a cycle where piece_valid && piece_ready
  // are both high at the clock edge, unless start is also high in that cycle.

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  seq_state_t    state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [2:0]    last_q, last_d;
  logic [31:0]   seed_q, seed_d;

  logic          q_flush, q_push, q_pop, q_full, decide;
  logic [2:0]    q_push_data;
  logic [CW-1:0] q_count;
  logic [2:0]    cand, cand2;
  int            cnt_after;
  logic          unused_rng_bits;

  assign cand            = rng_state[2:0];
  assign cand2           = mod7_5b(rng_state[4:0]);
  assign unused_rng_bits = ^rng_state[31:5];
  assign q_full          = (q_count == CW'(QDEPTH));

  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    last_d      = last_q;
    seed_d      = seed_q;
    q_flush     = 1'b0;
    q_push      = 1'b0;
    q_push_data = 3'd0;
    q_pop       = piece_valid && piece_ready;
    decide      = 1'b0;
    cnt_after   = 0;
    if (start) begin
      q_flush = 1'b1;
      q_pop   = 1'b0;
      last_d  = PIECE_NONE;
      warm_d  = '0;
      seed_d  = (seed_in == 32'd0) ? DEFAULT_SEED : seed_in;
      state_d = ST_SEED;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_SEED: begin
          warm_d  = '0;
          state_d = ST_WARM;
        end
        ST_WARM: begin
          if (warm_q == WW'(WARMUP - 1)) state_d = ST_ROLL;
          else                           warm_d  = warm_q + 1'b1;
        end
        ST_ROLL: begin
          if (q_full) begin
            state_d = ST_READY;
          end else if (cand != PIECE_NONE && cand != last_q) begin
            q_push      = 1'b1;
            q_push_data = cand;
            last_d      = cand;
            decide      = 1'b1;
          end else begin
            state_d = ST_REROLL;
          end
        end
        ST_REROLL: begin
          if (q_full) begin
            state_d = ST_READY;
          end else begin
            q_push      = 1'b1;
            q_push_data = cand2;
            last_d      = cand2;
            decide      = 1'b1;
          end
        end
        ST_READY: begin
          if (q_pop || !q_full) state_d = ST_ROLL;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Keep rolling while the queue, after this cycle's push/pop, still has room.
    if (decide) begin
      cnt_after = int'(q_count) + (q_push ? 1 : 0) - (q_pop ? 1 : 0);
      state_d   = (cnt_after < QDEPTH) ? ST_ROLL : ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      warm_q  <= '0;
      last_q  <= PIECE_NONE;
      seed_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      last_q  <= last_d;
      seed_q  <= seed_d;
    end
  end

  piece_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (q_flush),
    .push_i        (q_push),
    .push_data_i   (q_push_data),
    .pop_i         (q_pop),
    .count_o       (q_count),
    .head_valid_o  (piece_valid),
    .head_o        (piece_id),
    .head1_valid_o (preview_valid),
    .head1_o       (preview_id)
  );

  assign rng_load    = (state_q == ST_SEED);
  assign rng_seed    = seed_q;
  assign busy        = (state_q == ST_SEED) || (state_q == ST_WARM) ||
                       ((state_q != ST_IDLE) && !q_full);
  assign dbg_state_o = state_q;

endmodule

// File: doc/piece_sequencer.md
# piece_sequencer

Controller that owns the `hw_rng` block and turns its raw state into a stream of tetromino IDs for the game logic. It seeds the RNG on `start`, waits out a warm-up period, and applies the NES-style roll/reroll rule. Accepted pieces go into a small FIFO, and the block exposes the current piece through a valid/ready handshake, plus a one-piece preview. It sits between `hw_rng` and the playfield/game FSM, and drives `hw_rng`'s `load`/`seed` inputs exclusively.

## Interface
- `WARMUP`, 16: number of cycles between seed load and the first roll (≥1).
- `QDEPTH`, 2: piece FIFO depth (≥2; entry 0 = current, entry 1 = preview).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse. Seeds the RNG and flushes the queue.
- `seed_in` in 32: seed value captured on `start`.
- `rng_load` out 1: drives `hw_rng.load`.
- `rng_seed` out 32: drives `hw_rng.seed`.
- `rng_state` in 32: from `hw_rng.random_state`. It advances once per `clk` while `rng_load` = 0.
- `piece_valid` out 1: head of queue is valid.
- `piece_ready` in 1: consumer accepts the head.
- `piece_id` out 3: head piece (`piece_t`).
- `preview_valid` out 1: second entry is valid.
- `preview_id` out 3: second entry.
- `busy` out 1: high in SEED/WARM, and while the queue is not full.

## Operation
- States are IDLE, SEED, WARM, ROLL, REROLL, READY.
- **IDLE.** Waits for `start`; no rolls are performed.
- **Seeding on `start` (from any state).**
  - The queue is flushed and `last` is set to `PIECE_NONE` (7).
  - The block enters SEED.
- **SEED** lasts 1 cycle.
  - `rng_load` = 1.
  - `rng_seed` = `seed_in`, or 32'h1F if `seed_in` = 0 (avoids the LFSR lock-up state).
  - Next state is WARM.
- **WARM.** A counter runs for `WARMUP` cycles, then the block enters ROLL.
- **ROLL.**
  - Candidate `c` = `rng_state[2:0]`.
  - If `c` ≠ 7 and `c` ≠ `last`: push `c`, set `last` = `c`, and go to READY. If the queue is still not full, stay in ROLL instead.
  - Otherwise go to REROLL.
- **REROLL** (one cycle later, so the RNG state is fresh).
  - `c2` = `rng_state[4:0]` mod 7, computed as a 5-bit unsigned value, giving 0..6.
  - `c2` is pushed unconditionally, even if it equals `last`; `last` = `c2`.
  - Next state is ROLL if the queue is still not full, else READY.
- **READY.** On a pop (`piece_valid` && `piece_ready`), the head is removed and the block goes to ROLL to refill.
- **Rolls only occur when the queue is not full.** No push is ever issued to a full queue.
- **Queue outputs.**
  - `piece_valid` = (count ≥ 1); `preview_valid` = (count ≥ 2).
  - Ids are taken from the head and head+1 entries; an id is 0 when its valid is low.
- **Simultaneous pop and push** in the same cycle: count is unchanged and ordering is preserved.
- **`start` during a handshake.** `start` wins; a pop in the same cycle is discarded.
- **`reset`** at any point, including mid-WARM or REROLL: all state and outputs return to their reset values and the block enters IDLE.
- **Reset values:**
  - `rng_load` = 0, `rng_seed` = 0.
  - `piece_valid` = 0, `preview_valid` = 0.
  - `piece_id` = 0, `preview_id` = 0.
  - `busy` = 0, `last` = 7, count = 0.

## Timing
- All outputs are registered or derived from registered state.
- `start` at cycle T:
  - SEED occupies T+1, with `rng_load` high for exactly one cycle.
  - WARM occupies T+2 .. T+1+`WARMUP`.
  - The first ROLL is at T+2+`WARMUP`.
- Push latency: 1 cycle after an accepted ROLL, or 2 cycles if the roll goes through REROLL.
- The queue is full after `QDEPTH` to 2·`QDEPTH` roll cycles.
- After a pop at cycle P, the freed slot is refilled by P+2 (or by P+3 with a reroll).
- `piece_id` is stable while `piece_valid` && !`piece_ready`.
- Pop updates `piece_id` and `preview_id` at P+1.

## Structure
- `tetris_pkg` contains:
  - the `piece_t` enum: I=0, O=1, T=2, S=3, Z=4, J=5, L=6;
  - `PIECE_NONE` = 3'd7;
  - the `seq_state_t` enum;
  - `DEFAULT_SEED` = 32'h1F.
- Sub-module `piece_queue` is a parameterised circular FIFO (`QDEPTH` × 3 bits) with push, pop, count, head and head+1 read ports, and simultaneous push/pop support.
- The FSM, warm-up counter and roll arithmetic live in `piece_sequencer`.

## Test plan
The bench drives `rng_state` directly.

1. **Reset and seed.** Hold `reset` for 3 cycles → all outputs are 0. Then pulse `start` with `seed_in` = 0 → one cycle later `rng_load` = 1 and `rng_seed` = 32'h1F; `busy` = 1.
2. **Plain accept.** `WARMUP` = 4. At the first ROLL, drive `rng_state` = 32'h3 → `piece_id` = 3 (S), `piece_valid` = 1 on the next cycle.
3. **Repeat reroll.** With `last` = 3, drive `rng_state` = 3, then 32'h14 (20) on the next cycle → the pushed preview is 20 mod 7 = 6 (L).
4. **Seven reroll.** Drive `rng_state` = 7, then 32'h1F → pushed value is 31 mod 7 = 3, accepted even when `last` = 3.
5. **Full-queue handshake.** Queue full with {2, 5}; hold `piece_ready` = 1 for one cycle while `rng_state` = 1 → next cycle `piece_id` = 5, followed by `preview_id` = 1; count never exceeds `QDEPTH`.
6. **Reset mid-operation.** Assert `reset` in WARM cycle 2 → IDLE, `busy` = 0, no `rng_load` pulse. A following `start` restarts the full sequence with the original `WARMUP`.
